// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed parallel-to-serial transmitter (start, data, parity, stop).
// Ports: C/CLR clock and async clear, LOAD_* valid/ready word input, SDO/FRAME/DONE registered outputs.
module serial_frame_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 0,
   parameter int PARITY    = 0
) (
   input  logic             C,
   input  logic             CLR,
   input  logic [WIDTH-1:0] LOAD_DATA,
   input  logic             LOAD_VALID,
   output logic             LOAD_READY,
   output logic             SDO,
   output logic             FRAME,
   output logic             DONE
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [2:0]       r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_par;
   logic             r_sdo;
   logic             r_frame;
   logic             r_done;

   logic             w_accept;
   logic             w_head;
   logic [WIDTH-1:0] w_shifted;
   logic             w_last;
   logic             w_par_calc;

   assign LOAD_READY = (r_state == S_IDLE) | (r_state == S_STOP);
   assign w_accept   = LOAD_VALID & LOAD_READY;

   assign w_head    = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
   assign w_shifted = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                       : {1'b0, r_shift[WIDTH-1:1]};
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   // Evaluated in START while the shift register still holds the whole word.
   assign w_par_calc = (PARITY == 2) ? ~(^r_shift) : (^r_shift);

   // Every output is registered together with the state it belongs to,
   // so SDO/FRAME/DONE only move on posedge C or CLR.
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_par   <= 1'b0;
         r_sdo   <= 1'b1;
         r_frame <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shift <= LOAD_DATA;
                  r_state <= S_START;
                  r_sdo   <= 1'b0;
                  r_frame <= 1'b1;
               end
            end
            S_START: begin
               r_par   <= w_par_calc;
               r_sdo   <= w_head;
               r_shift <= w_shifted;
               r_cnt   <= '0;
               r_state <= S_DATA;
            end
            S_DATA: begin
               if (w_last) begin
                  if (PARITY != 0) begin
                     r_state <= S_PAR;
                     r_sdo   <= r_par;
                  end else begin
                     r_state <= S_STOP;
                     r_sdo   <= 1'b1;
                  end
               end else begin
                  r_sdo   <= w_head;
                  r_shift <= w_shifted;
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            S_PAR: begin
               r_state <= S_STOP;
               r_sdo   <= 1'b1;
            end
            S_STOP: begin
               r_done <= 1'b1;
               // A word taken here starts the next frame with no idle gap.
               if (w_accept) begin
                  r_shift <= LOAD_DATA;
                  r_state <= S_START;
                  r_sdo   <= 1'b0;
                  r_frame <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_sdo   <= 1'b1;
                  r_frame <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_sdo   <= 1'b1;
               r_frame <= 1'b0;
            end
         endcase
      end
   end

   assign SDO   = r_sdo;
   assign FRAME = r_frame;
   assign DONE  = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed vectors for serial_frame_tx in three configurations.
// Unit 0: LSB-first even parity, unit 1: MSB-first odd, unit 2: MSB-first no parity.
module tb_serial_frame_tx;

   logic       C;
   logic       CLR;
   logic [7:0] dat [3];
   logic [2:0] val;
   logic [2:0] rdy;
   logic [2:0] sdo;
   logic [2:0] frm;
   logic [2:0] dn;
   logic       q;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          unit;
      logic [7:0]  data;
      int          nbits;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [6];

   serial_frame_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY(1)) u_even (
      .C(C), .CLR(CLR), .LOAD_DATA(dat[0]), .LOAD_VALID(val[0]),
      .LOAD_READY(rdy[0]), .SDO(sdo[0]), .FRAME(frm[0]), .DONE(dn[0]));

   serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY(2)) u_odd (
      .C(C), .CLR(CLR), .LOAD_DATA(dat[1]), .LOAD_VALID(val[1]),
      .LOAD_READY(rdy[1]), .SDO(sdo[1]), .FRAME(frm[1]), .DONE(dn[1]));

   serial_frame_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY(0)) u_none (
      .C(C), .CLR(CLR), .LOAD_DATA(dat[2]), .LOAD_VALID(val[2]),
      .LOAD_READY(rdy[2]), .SDO(sdo[2]), .FRAME(frm[2]), .DONE(dn[2]));

   // downstream negedge capture flop sharing C and CLR
   always_ff @(negedge C or posedge CLR) begin
      if (CLR) q <= 1'b0;
      else     q <= sdo[0];
   end

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v);
      int u;
      u = v.unit;
      @(negedge C);
      dat[u] = v.data;
      val[u] = 1'b1;
      for (int i = 0; i < v.nbits; i++) begin
         @(negedge C);
         #1;
         if (i == 0) val[u] = 1'b0;
         dat[u] = 8'($urandom);
         chk($sformatf("u%0d sdo bit%0d", u, i), 32'(sdo[u]),
             32'(v.exp[v.nbits-1-i]));
         chk($sformatf("u%0d frame bit%0d", u, i), 32'(frm[u]), 32'd1);
         chk($sformatf("u%0d ready bit%0d", u, i), 32'(rdy[u]),
             32'(i == v.nbits - 1));
         chk($sformatf("u%0d done bit%0d", u, i), 32'(dn[u]), 32'd0);
         if (u == 0)
            chk($sformatf("capture q bit%0d", i), 32'(q),
                32'(v.exp[v.nbits-1-i]));
      end
      @(negedge C);
      #1;
      chk($sformatf("u%0d done pulse", u), 32'(dn[u]), 32'd1);
      chk($sformatf("u%0d frame end", u), 32'(frm[u]), 32'd0);
      chk($sformatf("u%0d idle sdo", u), 32'(sdo[u]), 32'd1);
      chk($sformatf("u%0d idle ready", u), 32'(rdy[u]), 32'd1);
      @(negedge C);
      #1;
      chk($sformatf("u%0d done single", u), 32'(dn[u]), 32'd0);
   endtask

   logic [21:0] b2b;
   logic [10:0] ab;

   initial begin
      vecs[0] = '{0, 8'hA5, 11, 16'(11'b01010010101)};
      vecs[1] = '{1, 8'h81, 11, 16'(11'b01000000111)};
      vecs[2] = '{2, 8'h81, 10, 16'(10'b0100000011)};
      vecs[3] = '{0, 8'h3C, 11, 16'(11'b00011110001)};
      vecs[4] = '{1, 8'hFF, 11, 16'(11'b01111111111)};
      vecs[5] = '{2, 8'h00, 10, 16'(10'b0000000001)};

      CLR = 1'b0;
      val = 3'b111;
      for (int u = 0; u < 3; u++) dat[u] = 8'h55;

      // clear mid-phase, no clock edge involved
      #2 CLR = 1'b1;
      #1;
      chk("rst sdo", 32'(sdo), 32'b111);
      chk("rst frame", 32'(frm), 32'b000);
      chk("rst done", 32'(dn), 32'b000);
      chk("rst ready", 32'(rdy), 32'b111);

      repeat (3) @(negedge C);
      #1;
      chk("rst hold frame", 32'(frm), 32'b000);
      chk("rst hold sdo", 32'(sdo), 32'b111);

      // first edge after release accepts on unit 0 only
      val[1] = 1'b0;
      val[2] = 1'b0;
      CLR = 1'b0;
      @(negedge C);
      #1;
      val[0] = 1'b0;
      chk("release accept frame", 32'(frm[0]), 32'd1);
      chk("release accept sdo", 32'(sdo[0]), 32'd0);
      chk("release idle u1", 32'(frm[1]), 32'd0);
      repeat (12) @(negedge C);
      #1;
      chk("release frame done", 32'(frm[0]), 32'd0);

      for (int k = 0; k < 6; k++) run_frame(vecs[k]);

      // back-to-back 0x0F then 0xF0 on unit 0
      b2b = {11'b01111000001, 11'b00000111101};
      @(negedge C);
      dat[0] = 8'h0F;
      val[0] = 1'b1;
      for (int i = 0; i < 22; i++) begin
         @(negedge C);
         #1;
         if (i == 0) dat[0] = 8'hF0;
         if (i == 11) val[0] = 1'b0;
         if (i > 11) dat[0] = 8'($urandom);
         chk($sformatf("b2b sdo %0d", i), 32'(sdo[0]), 32'(b2b[21-i]));
         chk($sformatf("b2b frame %0d", i), 32'(frm[0]), 32'd1);
         chk($sformatf("b2b ready %0d", i), 32'(rdy[0]),
             32'(i == 10 || i == 21));
         chk($sformatf("b2b done %0d", i), 32'(dn[0]), 32'(i == 11));
      end
      @(negedge C);
      #1;
      chk("b2b final done", 32'(dn[0]), 32'd1);
      chk("b2b final frame", 32'(frm[0]), 32'd0);

      // abort during data bit 4
      ab = 11'b01010010101;
      @(negedge C);
      dat[0] = 8'hA5;
      val[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge C);
         #1;
         if (i == 0) val[0] = 1'b0;
         chk($sformatf("abort pre sdo %0d", i), 32'(sdo[0]), 32'(ab[10-i]));
      end
      #1 CLR = 1'b1;
      #1;
      chk("abort sdo", 32'(sdo[0]), 32'd1);
      chk("abort frame", 32'(frm[0]), 32'd0);
      chk("abort done", 32'(dn[0]), 32'd0);
      chk("abort ready", 32'(rdy[0]), 32'd1);
      @(negedge C);
      CLR = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge C);
         #1;
         chk($sformatf("abort no done %0d", i), 32'(dn[0]), 32'd0);
         chk($sformatf("abort idle %0d", i), 32'(frm[0]), 32'd0);
      end
      run_frame(vecs[3]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
